// File: rtl/jtriders_busarb.sv
// 68000-style BR/BG/BGACK arbiter for two DMA masters, with a memory-port mux
// that hands the shared SDRAM/RAM port to whichever master owns the bus.
module jtriders_busarb (
   input  logic        rst,
   input  logic        clk,
   input  logic        cen,
   input  logic        cpu_asn,
   input  logic        cpu_cs,
   input  logic        cpu_we,
   input  logic [23:1] cpu_addr,
   input  logic [1:0]  cpu_dsn,
   input  logic [15:0] cpu_dout,
   input  logic [1:0]  br_n,
   input  logic [1:0]  bgack_n,
   output logic [1:0]  bg_n,
   output logic        cpu_halt,
   input  logic [23:1] m0_addr,
   input  logic        m0_we,
   input  logic [1:0]  m0_dsn,
   input  logic [15:0] m0_dout,
   input  logic [23:1] m1_addr,
   input  logic        m1_we,
   input  logic [1:0]  m1_dsn,
   input  logic [15:0] m1_dout,
   output logic        mem_cs,
   output logic [23:1] mem_addr,
   output logic        mem_we,
   output logic [1:0]  mem_dsn,
   output logic [15:0] mem_din,
   input  logic        mem_ok,
   output logic        bus_busy,
   output logic [1:0]  dbg_state,
   output logic        dbg_owner,
   output logic        dbg_last
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_OWNED   = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t     state_q;
   logic       owner_q;
   logic       last_q;
   logic [1:0] bg_n_q;
   logic       halt_q;

   logic       winner;
   logic       any_req;
   logic       own_bgack_n;
   logic       own_br_n;

   // Lone requester wins outright; contention alternates away from last_q.
   always_comb begin
      if (br_n == 2'b00) winner = ~last_q;
      else               winner = br_n[0];
   end

   assign any_req     = (br_n != 2'b11);
   assign own_bgack_n = bgack_n[owner_q];
   assign own_br_n    = br_n[owner_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         bg_n_q  <= 2'b11;
         halt_q  <= 1'b0;
      end else if (cen) begin
         case (state_q)
            ST_IDLE: begin
               // Only grant between CPU cycles so a bus cycle is never cut short.
               if (any_req && cpu_asn) begin
                  owner_q         <= winner;
                  bg_n_q          <= 2'b11;
                  bg_n_q[winner]  <= 1'b0;
                  halt_q          <= 1'b1;
                  state_q         <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!own_bgack_n) begin
                  bg_n_q  <= 2'b11;
                  state_q <= ST_OWNED;
               end else if (own_br_n) begin
                  bg_n_q  <= 2'b11;
                  halt_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_OWNED: begin
               if (own_bgack_n) begin
                  last_q  <= owner_q;
                  state_q <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               halt_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bg_n     = bg_n_q;
   assign cpu_halt = halt_q;

   always_comb begin
      mem_cs   = cpu_cs;
      mem_addr = cpu_addr;
      mem_we   = cpu_we;
      mem_dsn  = cpu_dsn;
      mem_din  = cpu_dout;
      if (state_q == ST_OWNED) begin
         if (owner_q) begin
            mem_cs   = (m1_dsn != 2'b11) | m1_we;
            mem_addr = m1_addr;
            mem_we   = m1_we;
            mem_dsn  = m1_dsn;
            mem_din  = m1_dout;
         end else begin
            mem_cs   = (m0_dsn != 2'b11) | m0_we;
            mem_addr = m0_addr;
            mem_we   = m0_we;
            mem_dsn  = m0_dsn;
            mem_din  = m0_dout;
         end
      end
   end

   assign bus_busy  = mem_cs & ~mem_ok;
   assign dbg_state = state_q;
   assign dbg_owner = owner_q;
   assign dbg_last  = last_q;

endmodule

// File: doc/jtriders_busarb.md
# jtriders_busarb

Bus arbiter for the riders-family 68000 bus. It emulates the CPU-side BR/BG/BGACK handshake for two DMA masters: requester 0 is the protection-chip DMA and requester 1 is the secondary DMA (e.g. object-RAM copy). It halts the CPU while a DMA master owns the bus and multiplexes the shared memory port between the CPU and the current owner. It sits between the main CPU, the DMA masters and the SDRAM/RAM decoder.

## Interface
- No parameters.
- `rst` in 1: asynchronous reset, active-high.
- `clk` in 1: single system clock.
- `cen` in 1: CPU clock enable; all arbitration decisions happen only on `cen`.
- `cpu_asn` in 1: CPU address strobe, active-low; the bus is grantable only while high.
- `cpu_cs`, `cpu_we` in 1 each; `cpu_addr` in 23 [23:1]; `cpu_dsn` in 2; `cpu_dout` in 16: CPU memory request.
- `br_n` in 2: bus requests, active-low, bit n = requester n.
- `bgack_n` in 2: bus-grant acknowledge, active-low.
- `bg_n` out 2: bus grant, active-low.
- `cpu_halt` out 1: high while the CPU must not start a bus cycle.
- `m0_addr`, `m1_addr` in 23 [23:1]; `m0_we`, `m1_we` in 1; `m0_dsn`, `m1_dsn` in 2; `m0_dout`, `m1_dout` in 16: DMA master requests. Master n requests an access when `mn_dsn != 2'b11`.
- `mem_cs` out 1; `mem_addr` out 23; `mem_we` out 1; `mem_dsn` out 2; `mem_din` out 16: shared memory port.
- `mem_ok` in 1: memory data valid / write done.
- `bus_busy` out 1: `mem_cs & ~mem_ok`, routed to the current owner.

## Operation
- States: IDLE (CPU owns), GRANT (BG issued, waiting for BGACK), OWNED (DMA master n drives the bus), RELEASE (one `cen` of dead time).
- Register `owner` (1 bit) holds the granted requester. Register `last` records the last serviced requester and resets to 1.
- IDLE, on `cen`: the grant fires if any `br_n` bit is low and `cpu_asn` is high.
  - Winner: the single requester if only one asks.
  - If both ask: `~last` (round robin).
  - Actions: `owner` <= winner, `bg_n[winner]` <= 0, `cpu_halt` <= 1, go to GRANT.
  - If `cpu_asn` is low, the request waits. No partial CPU cycle is ever cut.
- GRANT, on `cen`:
  - If `bgack_n[owner]` is low: `bg_n[owner]` <= 1, go to OWNED.
  - Else if `br_n[owner]` is high (request withdrawn): `bg_n` <= 2'b11, `cpu_halt` <= 0, go to IDLE, leave `last` unchanged.
- OWNED: memory port = master `owner` signals.
  - `mem_cs` = (`m<owner>_dsn != 2'b11`) | `m<owner>_we`.
  - When `bgack_n[owner]` goes high on `cen`: `last` <= `owner`, go to RELEASE.
- RELEASE: on the next `cen`, `cpu_halt` <= 0, go to IDLE. The CPU always gets at least one `cen` before the next grant.
- In IDLE and GRANT the memory port passes the CPU request: `mem_cs` = `cpu_cs`.
- The memory mux is combinational from state/`owner`. `bus_busy` is combinational.
- A `bgack_n` low from a non-owner is ignored and does not change state.
- Reset mid-operation: every register returns to its reset value at once. The memory port reverts to the CPU in the same cycle.

## Timing
- Reset values: `bg_n` = 2'b11, `cpu_halt` = 0, state IDLE, `owner` = 0, `last` = 1, `mem_cs` = `cpu_cs` (CPU path).
- Grant latency: `bg_n` falls on the first `cen` edge with a request and `cpu_asn` high, i.e. 1 `cen` after the request is visible.
- BGACK to ownership: OWNED is entered at the `cen` sampling `bgack_n` low. The mux switches the next `clk`.
- Release: `cpu_halt` drops 2 `cen` after `bgack_n` rises (OWNED→RELEASE→IDLE).
- If requests arrive in the same `cen` that RELEASE exits, they are not granted until the following `cen`.
- All outputs except the mux and `bus_busy` are registered.

## Test plan
- Single request, CPU idle: `br_n` = 2'b10, `cpu_asn` = 1 → `bg_n` = 2'b10 after 1 `cen`, `cpu_halt` = 1. Then `bgack_n` = 2'b10 → `bg_n` = 2'b11 and `mem_addr` follows `m0_addr`. Then `bgack_n` high → `cpu_halt` = 0 two `cen` later.
- CPU mid-cycle: `br_n[1]` low while `cpu_asn` = 0 for 5 `cen` → `bg_n` stays 2'b11 until the first `cen` with `cpu_asn` = 1.
- Simultaneous requests after reset: `br_n` = 2'b00 → requester 0 is granted first. After its release, with `br_n[0]` still low, requester 1 is granted (round robin).
- Withdrawn request: `br_n[0]` low, then high before any `bgack_n` → `bg_n` = 2'b11, `cpu_halt` = 0, state IDLE, `last` unchanged.
- Memory port: in OWNED with `m1_dsn` = 2'b00, `m1_addr` = 0x0C0000, `mem_ok` low for 3 clk → `mem_cs` = 1, `mem_addr` = 0x0C0000, `bus_busy` = 1 for 3 clk, then 0.
- Reset asserted during OWNED → `bg_n` = 2'b11, `cpu_halt` = 0, `mem_cs` = `cpu_cs` immediately.
